spi_sram_responder: RTL and testbench
=====================================

// Module: spi_sram_responder
// PURPOSE
//  Synthesizable SPI-SRAM responder: the device end of the sram_cs/sram_si/sram_so link
//  that memory_controller drives for the CPU. Decodes 8-bit READ/WRITE opcodes, a 24-bit
//  address and 16-bit MSB-first data words into an internal word array. Used as the
//  on-chip/bench stand-in for the external SRAM, so CPU programs run without the real part.
// PARAMETERS
//  DEPTH    16  words of storage (power of 2); word index = address mod DEPTH
//  ADDR_W   24  address bits shifted in after the opcode
//  WORD_W   16  data bits per word (matches WORD_SIZE)
// PORTS
//  clk         in   1       system clock; all logic on posedge
//  rst         in   1       synchronous, active-high reset
//  ena         in   1       high when enabled; low freezes all state (outputs hold)
//  sram_cs     in   1       chip select, active low
//  sram_sck    in   1       SPI clock, mode 0, asynchronous to clk, <= clk/8
//  sram_si     in   1       serial data in (controller -> SRAM)
//  sram_so     out  1       serial data out (SRAM -> controller)
//  sram_so_oe  out  1       high while sram_so is driven (read data phase only)
//  busy        out  1       high from cs fall until cs rise/abort
//  cmd_error   out  1       one-cycle pulse on unsupported opcode
// BEHAVIOUR
//  - Reset: sram_so=0, sram_so_oe=0, busy=0, cmd_error=0, state=IDLE, counters=0,
//    every storage word=0. Reset mid-transaction aborts it; no partial write commits.
//  - sck and cs pass a 2-FF synchronizer; rise/fall of sck detected on synced copy.
//    Latency sck pin edge -> action: 3 clk cycles. si captured alongside sck (same sync).
//  - Mode 0: sample si on sck rise; update so on sck fall. Bits MSB first.
//  - States: IDLE -> CMD (8 rises) -> ADDR (ADDR_W rises) -> RDATA | WDATA; any -> IGNORE.
//    IDLE: on synced cs fall -> CMD, busy=1, bit counter=0.
//    CMD: after 8th rise, opcode 8'h03 -> ADDR(read), 8'h02 -> ADDR(write),
//      else cmd_error pulse next cycle, -> IGNORE (so_oe stays 0).
//    ADDR: shift ADDR_W bits; word index = addr[log2(DEPTH)-1:0]; upper bits ignored.
//    RDATA: on the sck fall after the last address rise, load shift reg from mem[idx],
//      so_oe=1, so=bit15; each following fall shifts next bit. After 16th bit has been
//      presented, the next fall loads mem[idx+1] (sequential burst, wraps DEPTH-1 -> 0).
//    WDATA: shift 16 rises; on 16th rise write mem[idx], idx+=1 (wrap DEPTH-1 -> 0).
//    IGNORE: wait for cs rise.
//  - Synced cs rise in any state: -> IDLE same cycle, so_oe=0, so=0, busy=0; a partially
//    shifted write word (<16 bits) is discarded; a completed word is already committed.
//  - cs rise and sck edge detected in same cycle: cs rise wins, the edge is dropped.
//  - Read of a word written earlier in the same burst returns the new value.
//  - ena=0: synchronizers and FSM hold; caller must not toggle SPI pins while disabled.
// STRUCTURE
//  - Shared header sram_defs.vh: SRAM_OP_READ 8'h03, SRAM_OP_WRITE 8'h02, state encodings
//    (IDLE/CMD/ADDR/RDATA/WDATA/IGNORE), WORD_SIZE reuse.
//  - One sub-module: spi_pin_sync (2-FF sync of sck/cs/si + sck rise/fall, cs rise/fall
//    pulses). FSM, bit counter (5b), address/data shift regs and storage array in top.
// TESTING
//  1 Write: cs low, 0x02, addr 0x000003, data 0xBEEF, cs high -> mem[3]=0xBEEF, busy 0.
//  2 Read: then 0x03, addr 0x000003, 16 clocks -> so yields 0xBEEF MSB first, so_oe=1 only
//    during the 16 data bits, 0 after cs rise.
//  3 Burst wrap: write addr 0x00000F data 0x1234,0x5678 -> mem[15]=0x1234, mem[0]=0x5678;
//    read burst from 0x00000F returns 0x1234 then 0x5678.
//  4 Abort: write addr 5, cs high after 8 data bits -> mem[5] unchanged (0), state IDLE.
//  5 Bad opcode 0xFF -> cmd_error high exactly 1 cycle, so_oe stays 0, next cs frame works.
//  6 Reset mid-read (after 4 data bits) -> next cycle so_oe=0, busy=0, all mem words 0.

Source files
------------

// File: rtl/spi_sram_responder_pkg.sv
// Shared opcodes, sizes and FSM state encoding for the SPI-SRAM responder.
package spi_sram_responder_pkg;

    localparam logic [7:0]  SRAM_OP_READ  = 8'h03;
    localparam logic [7:0]  SRAM_OP_WRITE = 8'h02;
    localparam int unsigned WORD_SIZE     = 16;
    localparam int unsigned CMD_BITS      = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRdata,
        StWdata,
        StIgnore
    } state_e;

endpackage

// File: rtl/spi_sram_responder_pin_sync.sv
// Two-flop synchronizer for the SPI pins plus edge pulses on the synced sck and cs.
module spi_sram_responder_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sck,
    input  logic cs,
    input  logic si,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic si_sync
);

    // [0],[1] are the synchronizer, [2] is the previous synced value for edge detection
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] si_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= '0;
            cs_q  <= '1;
            si_q  <= '0;
        end else if (ena) begin
            sck_q <= {sck_q[1:0], sck};
            cs_q  <= {cs_q[1:0], cs};
            si_q  <= {si_q[0], si};
        end
    end

    assign sck_rise = ena & sck_q[1] & ~sck_q[2];
    assign sck_fall = ena & ~sck_q[1] & sck_q[2];
    assign cs_rise  = ena & cs_q[1] & ~cs_q[2];
    assign cs_fall  = ena & ~cs_q[1] & cs_q[2];
    assign si_sync  = si_q[1];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 SRAM stand-in: READ/WRITE opcodes, 24-bit address, 16-bit burst words.
module spi_sram_responder
    import spi_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned WORD_W = WORD_SIZE
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sram_cs,
    input  logic sram_sck,
    input  logic sram_si,
    output logic sram_so,
    output logic sram_so_oe,
    output logic busy,
    output logic cmd_error
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic sck_rise, sck_fall, cs_rise, cs_fall, si_s;

    spi_sram_responder_pin_sync u_pin_sync (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .sck      (sram_sck),
        .cs       (sram_cs),
        .si       (sram_si),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall),
        .si_sync  (si_s)
    );

    state_e                 state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [CMD_BITS-1:0]    cmd_q, cmd_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   is_read_q, is_read_d;
    logic                   so_q, so_d;
    logic                   so_oe_q, so_oe_d;
    logic                   busy_q, busy_d;
    logic                   cmd_error_q, cmd_error_d;
    logic [WORD_W-1:0]      mem_q [DEPTH];
    logic                   mem_we;
    logic [WORD_W-1:0]      mem_wdata;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        idx_d       = idx_q;
        data_d      = data_q;
        is_read_d   = is_read_q;
        so_d        = so_q;
        so_oe_d     = so_oe_q;
        busy_d      = busy_q;
        cmd_error_d = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = {data_q[WORD_W-2:0], si_s};

        // cs rise wins over any sck edge seen in the same cycle
        if (cs_rise) begin
            state_d   = StIdle;
            so_d      = 1'b0;
            so_oe_d   = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        cmd_d     = {cmd_q[CMD_BITS-2:0], si_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
                            bit_cnt_d = '0;
                            if (cmd_d == SRAM_OP_READ) begin
                                state_d   = StAddr;
                                is_read_d = 1'b1;
                            end else if (cmd_d == SRAM_OP_WRITE) begin
                                state_d   = StAddr;
                                is_read_d = 1'b0;
                            end else begin
                                state_d     = StIgnore;
                                cmd_error_d = 1'b1;
                            end
                        end
                    end
                end
                StAddr: begin
                    // only the low index bits are kept; upper address bits fall off the end
                    if (sck_rise) begin
                        idx_d     = IDX_W'({idx_q, si_s});
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(ADDR_W - 1)) begin
                            bit_cnt_d = '0;
                            state_d   = is_read_q ? StRdata : StWdata;
                        end
                    end
                end
                StRdata: begin
                    if (sck_fall) begin
                        so_oe_d = 1'b1;
                        if (bit_cnt_q == '0) begin
                            so_d   = mem_q[idx_q][WORD_W-1];
                            data_d = {mem_q[idx_q][WORD_W-2:0], 1'b0};
                        end else begin
                            so_d   = data_q[WORD_W-1];
                            data_d = {data_q[WORD_W-2:0], 1'b0};
                        end
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(WORD_W - 1)) begin
                            bit_cnt_d = '0;
                            idx_d     = idx_q + IDX_W'(1);
                        end
                    end
                end
                StWdata: begin
                    if (sck_rise) begin
                        data_d    = mem_wdata;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'(WORD_W - 1)) begin
                            mem_we    = 1'b1;
                            bit_cnt_d = '0;
                            idx_d     = idx_q + IDX_W'(1);
                        end
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            is_read_q   <= 1'b0;
            so_q        <= 1'b0;
            so_oe_q     <= 1'b0;
            busy_q      <= 1'b0;
            cmd_error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ena) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            is_read_q   <= is_read_d;
            so_q        <= so_d;
            so_oe_q     <= so_oe_d;
            busy_q      <= busy_d;
            cmd_error_q <= cmd_error_d;
            if (mem_we) begin
                mem_q[idx_q] <= mem_wdata;
            end
        end
    end

    assign sram_so    = so_q;
    assign sram_so_oe = so_oe_q;
    assign busy       = busy_q;
    assign cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench: drives SPI frames, models the word array, scoreboards read data.
module tb_spi_sram_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic sram_cs = 1'b1;
    logic sram_sck = 1'b0;
    logic sram_si = 1'b0;
    logic sram_so, sram_so_oe, busy, cmd_error;

    spi_sram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sram_cs    (sram_cs),
        .sram_sck   (sram_sck),
        .sram_si    (sram_si),
        .sram_so    (sram_so),
        .sram_so_oe (sram_so_oe),
        .busy       (busy),
        .cmd_error  (cmd_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] tb_mem [16];
    logic [15:0] sb_q [$];

    int   err_cycles = 0;
    logic oe_seen = 1'b0;

    always @(negedge clk) begin
        if (cmd_error === 1'b1) err_cycles++;
        if (sram_so_oe === 1'b1) oe_seen = 1'b1;
    end

    // sck half period of 8 clk; so is sampled just before the rising sck edge
    task automatic spi_bit(input logic b, output logic so_smp, output logic oe_smp);
        sram_si = b;
        repeat (8) @(negedge clk);
        so_smp = sram_so;
        oe_smp = sram_so_oe;
        sram_sck = 1'b1;
        repeat (8) @(negedge clk);
        sram_sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int n, output logic oe_any);
        logic s, o;
        oe_any = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_bit(val[i], s, o);
            if (o !== 1'b0) oe_any = 1'b1;
        end
    endtask

    task automatic cs_low();
        sram_cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        sram_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic write_burst(input int addr, input logic [15:0] w0, input logic [15:0] w1,
                               input int n, input string name);
        logic oe_any;
        cs_low();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_cs_fall got=%b want=1", name, busy);
        end
        send_bits(32'h02, 8, oe_any);
        send_bits(32'(addr), 24, oe_any);
        for (int i = 0; i < n; i++) begin
            send_bits(32'((i == 0) ? w0 : w1), 16, oe_any);
            tb_mem[(addr + i) % 16] = (i == 0) ? w0 : w1;
        end
        cs_high();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_cs_rise got=%b want=0", name, busy);
        end
    endtask

    task automatic read_burst(input int addr, input int n, input string name);
        logic oe_any, s, o, oe_bad;
        logic [15:0] word, exp;
        for (int i = 0; i < n; i++) sb_q.push_back(tb_mem[(addr + i) % 16]);
        cs_low();
        send_bits(32'h03, 8, oe_any);
        send_bits(32'(addr), 24, o);
        oe_any = oe_any | o;
        checks++;
        if (oe_any !== 1'b0) begin
            failures++;
            $display("FAIL %s oe_in_cmd_addr got=1 want=0", name);
        end
        for (int w = 0; w < n; w++) begin
            oe_bad = 1'b0;
            for (int b = 15; b >= 0; b--) begin
                spi_bit(1'b0, s, o);
                word[b] = s;
                if (o !== 1'b1) oe_bad = 1'b1;
            end
            checks++;
            if (oe_bad) begin
                failures++;
                $display("FAIL %s oe_in_data word=%0d got=0 want=1", name, w);
            end
            exp = sb_q.pop_front();
            checks++;
            if (word !== exp) begin
                failures++;
                $display("FAIL %s data word=%0d got=%h want=%h", name, w, word, exp);
            end
        end
        cs_high();
        checks++;
        if (sram_so_oe !== 1'b0 || sram_so !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_cs_rise oe/so/busy got=%b%b%b want=000", name,
                     sram_so_oe, sram_so, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        checks++;
        if ({sram_so, sram_so_oe, busy, cmd_error} !== 4'b0000) begin
            failures++;
            $display("FAIL reset so/oe/busy/err got=%b want=0000",
                     {sram_so, sram_so_oe, busy, cmd_error});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_read();
        write_burst(3, 16'hBEEF, 16'h0000, 1, "write3");
        read_burst(3, 1, "read3");
    endtask

    task automatic test_burst_wrap();
        write_burst(15, 16'h1234, 16'h5678, 2, "wrap_write");
        read_burst(15, 2, "wrap_read");
        read_burst(32'h00ABC3, 1, "upper_addr_ignored");
    endtask

    task automatic test_abort();
        logic oe_any;
        cs_low();
        send_bits(32'h02, 8, oe_any);
        send_bits(32'h5, 24, oe_any);
        send_bits(32'hA5, 8, oe_any);
        cs_high();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort busy got=%b want=0", busy);
        end
        read_burst(5, 1, "abort_read5");
    endtask

    task automatic test_bad_opcode();
        logic oe_any;
        err_cycles = 0;
        oe_seen = 1'b0;
        cs_low();
        send_bits(32'hFF, 8, oe_any);
        send_bits(32'h00, 8, oe_any);
        cs_high();
        checks++;
        if (err_cycles != 1) begin
            failures++;
            $display("FAIL bad_opcode cmd_error_cycles got=%0d want=1", err_cycles);
        end
        checks++;
        if (oe_seen !== 1'b0) begin
            failures++;
            $display("FAIL bad_opcode so_oe got=1 want=0");
        end
        read_burst(3, 1, "after_bad_opcode");
    endtask

    task automatic test_reset_mid_read();
        logic oe_any, s, o;
        cs_low();
        send_bits(32'h03, 8, oe_any);
        send_bits(32'h3, 24, oe_any);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, s, o);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        checks++;
        if (sram_so_oe !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read oe/busy got=%b%b want=00", sram_so_oe, busy);
        end
        cs_high();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read busy_after_cs got=%b want=0", busy);
        end
        read_burst(0, 16, "mem_cleared");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_abort();
        test_bad_opcode();
        test_reset_mid_read();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
